// File: rtl/acq_seq_pkg.sv
// Shared definitions for the acquisition sequencer: state encodings and
// the channel-search helper used by both the top and the channel picker.
package acq_seq_pkg;

  // Widest channel mask the sequencer supports.
  localparam int unsigned MAX_CH = 16;

  // State encodings. Three bits leave spare codes that must recover to IDLE.
  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_START_ENC = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC  = 3'd2;
  localparam logic [2:0] ST_GAP_ENC   = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_START = ST_START_ENC,
    ST_WAIT  = ST_WAIT_ENC,
    ST_GAP   = ST_GAP_ENC
  } state_e;

  // Index of the lowest set bit of mask at or above position from.
  // found is cleared when no such bit exists; the index is then 0.
  function automatic logic [3:0] lowest_set_from(input  logic [MAX_CH-1:0] mask,
                                                 input  logic [4:0]        from,
                                                 output logic              found);
    logic [3:0] idx;
    idx   = '0;
    found = 1'b0;
    // Scan downwards so the last hit kept is the lowest qualifying bit.
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= from)) begin
        idx   = 4'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/acq_sequencer_ch_pick.sv
// Next-channel selector: finds the next enabled channel strictly above the
// current one in the latched mask.
module ch_pick
  import acq_seq_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned CHW = 1
) (
  input  logic [NCH-1:0] mask_i,
  input  logic [CHW-1:0] cur_i,
  output logic [CHW-1:0] next_o,
  output logic           found_o
);

  logic [4:0] from;

  // Search starts one position above the active channel.
  always_comb begin
    from    = 5'(cur_i) + 5'd1;
    found_o = 1'b0;
    next_o  = CHW'(lowest_set_from(MAX_CH'(mask_i), from, found_o));
  end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: on a button rise, walks the enabled SPI channels
// one conversion at a time, optionally repeating after an idle gap.
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned CHW = 1,
  parameter int unsigned PW  = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           button_i,
  input  logic           mode_i,
  input  logic [PW-1:0]  period_i,
  input  logic [NCH-1:0] ch_mask_i,
  input  logic           z_i,
  input  logic           abort_i,
  output logic           start_o,
  output logic           en_o,
  output logic [CHW-1:0] ch_o,
  output logic           busy_o,
  output logic           scan_done_o
);

  state_e         state_q, state_d;
  logic [NCH-1:0] mask_q,  mask_d;
  logic [CHW-1:0] ch_q,    ch_d;
  logic [PW-1:0]  cnt_q,   cnt_d;
  logic           btn_q;
  logic           armed_q;

  logic           trig;
  logic [CHW-1:0] first_ch;
  logic           first_found;
  logic [CHW-1:0] nxt_ch;
  logic           nxt_found;

  // armed_q blocks the first cycle after reset so a button held through
  // reset release needs a fresh rise before it can start a scan.
  assign trig = button_i & ~btn_q & armed_q;

  // Lowest enabled channel of the live mask, used when a scan (re)starts.
  always_comb begin
    first_found = 1'b0;
    first_ch    = CHW'(lowest_set_from(MAX_CH'(ch_mask_i), 5'd0, first_found));
  end

  ch_pick #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_ch_pick (
    .mask_i  (mask_q),
    .cur_i   (ch_q),
    .next_o  (nxt_ch),
    .found_o (nxt_found)
  );

  // State, latched mask, channel index, gap counter and button history.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      ch_q    <= '0;
      cnt_q   <= '0;
      btn_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      btn_q   <= button_i;
      armed_q <= 1'b1;
    end
  end

  // Next-state and next-data decode; abort overrides everything else.
  // NOTE: every signal gets a hold default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trig && first_found) begin
            mask_d  = ch_mask_i;
            ch_d    = first_ch;
            state_d = ST_START;
          end
        end
        ST_START: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (z_i) begin
            if (nxt_found) begin
              ch_d    = nxt_ch;
              state_d = ST_START;
            end else if (mode_i) begin
              cnt_d   = period_i;
              state_d = ST_GAP;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            mask_d = ch_mask_i;
            if (mode_i && first_found) begin
              ch_d    = first_ch;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - PW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode from state; the done pulse also qualifies on this cycle's z_i.
  assign start_o     = (state_q == ST_START);
  assign en_o        = (state_q == ST_WAIT);
  assign busy_o      = (state_q != ST_IDLE);
  assign scan_done_o = (state_q == ST_WAIT) && z_i && !abort_i && !nxt_found;
  assign ch_o        = ch_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer with NCH=4: a vector table for the basic
// scan and abort paths, then hand sequences for gap timing, held button and
// mid-scan reset.
module tb_acq_sequencer;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;
  localparam int unsigned PW  = 16;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           button_i;
  logic           mode_i;
  logic [PW-1:0]  period_i;
  logic [NCH-1:0] ch_mask_i;
  logic           z_i;
  logic           abort_i;
  logic           start_o;
  logic           en_o;
  logic [CHW-1:0] ch_o;
  logic           busy_o;
  logic           scan_done_o;

  int n_vec = 0;
  int n_err = 0;

  acq_sequencer #(
    .NCH (NCH),
    .CHW (CHW),
    .PW  (PW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .button_i    (button_i),
    .mode_i      (mode_i),
    .period_i    (period_i),
    .ch_mask_i   (ch_mask_i),
    .z_i         (z_i),
    .abort_i     (abort_i),
    .start_o     (start_o),
    .en_o        (en_o),
    .ch_o        (ch_o),
    .busy_o      (busy_o),
    .scan_done_o (scan_done_o)
  );

  always #5 clk_i = ~clk_i;

  // One vector: inputs held for a cycle, outputs expected before its edge.
  typedef struct {
    logic           btn;
    logic [NCH-1:0] mask;
    logic           z;
    logic           ab;
    logic [5:0]     exp;   // {start, en, ch[1:0], busy, done}
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic btn, input logic [3:0] mask, input logic z,
                              input logic ab, input logic st, input logic en,
                              input logic [1:0] ch, input logic bsy, input logic dn);
    vec_t v;
    v.btn  = btn;
    v.mask = mask;
    v.z    = z;
    v.ab   = ab;
    v.exp  = {st, en, ch, bsy, dn};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {start_o, en_o, ch_o, busy_o, scan_done_o};
  endfunction

  initial begin
    int gap;
    int n_start;
    int n_done;
    int seen;

    rst_ni    = 1'b0;
    button_i  = 1'b0;
    mode_i    = 1'b0;
    period_i  = '0;
    ch_mask_i = '0;
    z_i       = 1'b0;
    abort_i   = 1'b0;

    // Scan of mask 1010, abort during WAIT, and zero-mask / held-button triggers.
    vecs[0]  = mk(0, 4'b1010, 0, 0, 0, 0, 2'd0, 0, 0);
    vecs[1]  = mk(1, 4'b1010, 0, 0, 0, 0, 2'd0, 0, 0);
    vecs[2]  = mk(1, 4'b1010, 0, 0, 1, 0, 2'd1, 1, 0);
    vecs[3]  = mk(1, 4'b1010, 0, 0, 0, 1, 2'd1, 1, 0);
    vecs[4]  = mk(1, 4'b1010, 1, 0, 0, 1, 2'd1, 1, 0);
    vecs[5]  = mk(1, 4'b1010, 1, 0, 1, 0, 2'd3, 1, 0);
    vecs[6]  = mk(1, 4'b1010, 0, 0, 0, 1, 2'd3, 1, 0);
    vecs[7]  = mk(1, 4'b1010, 1, 0, 0, 1, 2'd3, 1, 1);
    vecs[8]  = mk(0, 4'b1010, 0, 0, 0, 0, 2'd3, 0, 0);
    vecs[9]  = mk(1, 4'b1010, 0, 0, 0, 0, 2'd3, 0, 0);
    vecs[10] = mk(1, 4'b1010, 0, 0, 1, 0, 2'd1, 1, 0);
    vecs[11] = mk(1, 4'b1010, 1, 1, 0, 1, 2'd1, 1, 0);
    vecs[12] = mk(1, 4'b1010, 0, 0, 0, 0, 2'd1, 0, 0);
    vecs[13] = mk(0, 4'b1010, 0, 0, 0, 0, 2'd1, 0, 0);
    vecs[14] = mk(1, 4'b0000, 0, 0, 0, 0, 2'd1, 0, 0);
    vecs[15] = mk(1, 4'b0000, 0, 0, 0, 0, 2'd1, 0, 0);
    vecs[16] = mk(1, 4'b1010, 0, 0, 0, 0, 2'd1, 0, 0);

    // Reset state.
    step();
    check("reset_outs", 32'(outs()), 32'h0);
    step();
    rst_ni = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      button_i  = vecs[i].btn;
      ch_mask_i = vecs[i].mask;
      z_i       = vecs[i].z;
      abort_i   = vecs[i].ab;
      #1;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      step();
    end
    button_i = 1'b0;
    z_i      = 1'b0;
    abort_i  = 1'b0;
    step();

    // Continuous mode: period 3 gives four GAP cycles; mask re-latched at gap end.
    mode_i    = 1'b1;
    period_i  = 16'd3;
    ch_mask_i = 4'b0001;
    button_i  = 1'b1;
    step();
    check("cont_start", 32'({start_o, ch_o}), 32'({1'b1, 2'd0}));
    button_i = 1'b0;
    step();
    z_i = 1'b1;
    #1;
    check("cont_done1", 32'(scan_done_o), 32'd1);
    step();
    z_i       = 1'b0;
    ch_mask_i = 4'b0100;
    check("gap_outs", 32'({start_o, en_o, busy_o}), 32'({1'b0, 1'b0, 1'b1}));
    gap = 0;
    for (int i = 0; i < 20 && !start_o; i++) begin
      gap++;
      step();
    end
    check("gap_len", 32'(gap), 32'd4);
    check("restart_ch", 32'({start_o, ch_o}), 32'({1'b1, 2'd2}));
    step();
    z_i = 1'b1;
    #1;
    check("cont_done2", 32'(scan_done_o), 32'd1);
    step();
    z_i    = 1'b0;
    mode_i = 1'b0;
    seen   = 0;
    for (int i = 0; i < 20 && busy_o; i++) begin
      if (start_o) seen++;
      step();
    end
    check("mode_drop_idle", 32'(busy_o), 32'd0);
    check("mode_drop_nostart", 32'(seen), 32'd0);

    // Button held for many cycles: exactly one scan.
    ch_mask_i = 4'b0001;
    button_i  = 1'b1;
    z_i       = 1'b1;
    n_start   = 0;
    n_done    = 0;
    for (int i = 0; i < 12; i++) begin
      if (scan_done_o) n_done++;
      step();
      if (start_o) n_start++;
    end
    check("held_starts", 32'(n_start), 32'd1);
    check("held_dones", 32'(n_done), 32'd1);
    check("held_idle", 32'(busy_o), 32'd0);

    // Reset during WAIT with the button held high.
    z_i      = 1'b0;
    button_i = 1'b0;
    step();
    button_i = 1'b1;
    step();
    step();
    check("pre_rst_wait", 32'(en_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_outs", 32'(outs()), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen   = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy_o || start_o || en_o) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
